// File: rtl/gbf_flgact_fifo_ctrl.sv
// Stream FIFO built on a single-port flag SRAM: circular RAM pointers, write/read
// alternation on contention, and a 3-entry output buffer that hides the read latency.
module gbf_flgact_fifo_ctrl #(
    parameter int SRAM_DEPTH_BIT = 6,
    parameter int SRAM_WIDTH     = 28
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clear,
    input  logic                        in_vld,
    output logic                        in_rdy,
    input  logic [SRAM_WIDTH-1:0]       in_data,
    output logic                        out_vld,
    input  logic                        out_rdy,
    output logic [SRAM_WIDTH-1:0]       out_data,
    output logic [SRAM_DEPTH_BIT+1:0]   fill_cnt,
    output logic [SRAM_DEPTH_BIT-1:0]   ram_addr_w,
    output logic [SRAM_DEPTH_BIT-1:0]   ram_addr_r,
    output logic                        ram_write_en,
    output logic                        ram_read_en,
    output logic [SRAM_WIDTH-1:0]       ram_data_in,
    input  logic [SRAM_WIDTH-1:0]       ram_data_out
);

    localparam int DEPTH = 1 << SRAM_DEPTH_BIT;
    localparam logic [SRAM_DEPTH_BIT:0] DEPTH_CNT = (SRAM_DEPTH_BIT+1)'(DEPTH);

    logic [SRAM_DEPTH_BIT-1:0] r_wr_ptr;
    logic [SRAM_DEPTH_BIT-1:0] r_rd_ptr;
    logic [SRAM_DEPTH_BIT:0]   r_ram_cnt;
    logic                      r_inflight;
    logic [1:0]                r_ob_cnt;
    logic                      r_last_grant;
    logic [SRAM_WIDTH-1:0]     r_ob [3];

    logic                      w_flush;
    logic                      w_full;
    logic                      w_empty;
    logic                      w_rd_want;
    logic                      w_wr_fire;
    logic                      w_rd_fire;
    logic                      w_pop;
    logic [1:0]                w_ob_slot;
    logic [SRAM_WIDTH-1:0]     w_ob_up   [3];
    logic [SRAM_WIDTH-1:0]     w_ob_next [3];

    assign w_flush   = rst || clear;
    assign w_full    = (r_ram_cnt == DEPTH_CNT);
    assign w_empty   = (r_ram_cnt == '0);
    // Credit check: a read is only issued if the buffer can take its data.
    assign w_rd_want = !w_empty && (({1'b0, r_ob_cnt} + {2'b00, r_inflight}) < 3'd3);

    assign in_rdy    = !w_full && !(w_rd_want && !r_last_grant);
    assign w_wr_fire = in_vld && in_rdy && !w_flush;
    assign w_rd_fire = w_rd_want && !w_wr_fire && !w_flush;
    assign w_pop     = (r_ob_cnt != 2'd0) && out_rdy;
    assign w_ob_slot = r_ob_cnt - {1'b0, w_pop};

    always_ff @(posedge clk) begin
        if (w_flush) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_ram_cnt    <= '0;
            r_inflight   <= 1'b0;
            r_ob_cnt     <= 2'd0;
            r_last_grant <= 1'b0;
        end else begin
            if (w_wr_fire) begin
                r_wr_ptr  <= r_wr_ptr + 1'b1;
                r_ram_cnt <= r_ram_cnt + 1'b1;
            end else if (w_rd_fire) begin
                r_ram_cnt <= r_ram_cnt - 1'b1;
            end
            if (w_rd_fire) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_wr_fire) begin
                r_last_grant <= 1'b0;
            end else if (w_rd_fire) begin
                r_last_grant <= 1'b1;
            end
            r_inflight <= w_rd_fire;
            r_ob_cnt   <= r_ob_cnt + {1'b0, r_inflight} - {1'b0, w_pop};
        end
    end

    // Output buffer is a shift register with the head at entry 0; returning read
    // data lands in the first free slot after this cycle's pop.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_ob
            if (gi < 2) begin : g_up
                assign w_ob_up[gi] = r_ob[gi+1];
            end else begin : g_top
                assign w_ob_up[gi] = r_ob[gi];
            end
            assign w_ob_next[gi] = (r_inflight && (w_ob_slot == 2'(gi))) ? ram_data_out :
                                   w_pop                                  ? w_ob_up[gi]  :
                                                                            r_ob[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            r_ob[i] <= w_ob_next[i];
        end
    end

    assign out_vld      = (r_ob_cnt != 2'd0);
    assign out_data     = r_ob[0];
    assign fill_cnt     = (SRAM_DEPTH_BIT+2)'(r_ram_cnt)
                        + (SRAM_DEPTH_BIT+2)'(r_inflight)
                        + (SRAM_DEPTH_BIT+2)'(r_ob_cnt);
    assign ram_addr_w   = r_wr_ptr;
    assign ram_addr_r   = r_rd_ptr;
    assign ram_write_en = w_wr_fire;
    assign ram_read_en  = w_rd_fire;
    assign ram_data_in  = in_data;

endmodule

// File: tb/tb_gbf_flgact_fifo_ctrl.sv
// Bench for gbf_flgact_fifo_ctrl: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_gbf_flgact_fifo_ctrl;

    localparam int DB    = 2;
    localparam int W     = 28;
    localparam int DEPTH = 1 << DB;

    logic          clk = 1'b0;
    logic          rst, clear, in_vld, out_rdy;
    logic [W-1:0]  in_data;
    logic          in_rdy, out_vld;
    logic [W-1:0]  out_data;
    logic [DB+1:0] fill_cnt;
    logic [DB-1:0] ram_addr_w, ram_addr_r;
    logic          ram_write_en, ram_read_en;
    logic [W-1:0]  ram_data_in, ram_data_out;

    gbf_flgact_fifo_ctrl #(.SRAM_DEPTH_BIT(DB), .SRAM_WIDTH(W)) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .in_vld(in_vld), .in_rdy(in_rdy), .in_data(in_data),
        .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data),
        .fill_cnt(fill_cnt),
        .ram_addr_w(ram_addr_w), .ram_addr_r(ram_addr_r),
        .ram_write_en(ram_write_en), .ram_read_en(ram_read_en),
        .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
    );

    always #5 clk = ~clk;

    // Behavioural single-port RAM with one-cycle read latency.
    logic [W-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (ram_write_en) mem[ram_addr_w] <= ram_data_in;
        if (ram_read_en)  ram_data_out    <= mem[ram_addr_r];
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: words held in RAM, a pending read, and the output buffer.
    logic [W-1:0] m_ram_q[$];
    logic [W-1:0] m_ob_q[$];
    logic         m_inf = 1'b0;
    logic [W-1:0] m_inf_data;
    logic         m_lg = 1'b0;
    int           m_wp = 0;
    int           m_rp = 0;
    bit           started = 1'b0;

    always @(negedge clk) begin : cmp_blk
        bit e_full, e_want, e_rdy, e_wr, e_rd, e_vld;
        int e_fill;
        if (started) begin
            e_full = (m_ram_q.size() == DEPTH);
            e_want = (m_ram_q.size() != 0) && (m_ob_q.size() + int'(m_inf) < 3);
            e_rdy  = !e_full && !(e_want && !m_lg);
            e_wr   = in_vld && e_rdy && !rst && !clear;
            e_rd   = e_want && !e_wr && !rst && !clear;
            e_vld  = (m_ob_q.size() != 0);
            e_fill = m_ram_q.size() + int'(m_inf) + m_ob_q.size();
            chk("m_in_rdy", in_rdy, e_rdy);
            chk("m_out_vld", out_vld, e_vld);
            if (e_vld) chk("m_out_data", out_data, m_ob_q[0]);
            chk("m_fill_cnt", fill_cnt, e_fill);
            chk("m_write_en", ram_write_en, e_wr);
            chk("m_read_en", ram_read_en, e_rd);
            chk("m_addr_w", ram_addr_w, m_wp);
            chk("m_addr_r", ram_addr_r, m_rp);
            chk("m_data_in", ram_data_in, in_data);
            if (rst || clear) begin
                m_ram_q.delete();
                m_ob_q.delete();
                m_inf = 1'b0;
                m_lg  = 1'b0;
                m_wp  = 0;
                m_rp  = 0;
            end else begin
                if (e_vld && out_rdy) void'(m_ob_q.pop_front());
                if (m_inf) m_ob_q.push_back(m_inf_data);
                m_inf = e_rd;
                if (e_rd) begin
                    m_inf_data = m_ram_q.pop_front();
                    m_rp = (m_rp + 1) % DEPTH;
                    m_lg = 1'b1;
                end
                if (e_wr) begin
                    m_ram_q.push_back(in_data);
                    m_wp = (m_wp + 1) % DEPTH;
                    m_lg = 1'b0;
                end
            end
        end
    end

    task automatic push_n(input int n, input logic [W-1:0] base);
        int a = 0;
        in_vld  = 1'b1;
        in_data = base;
        for (int k = 0; k < 50 && a < n; k++) begin
            @(negedge clk);
            if (in_rdy) a++;
            tick();
            in_data = base + W'(a);
        end
        in_vld = 1'b0;
        chk("push_n_accepted", a, n);
    endtask

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        int acc, overlap, first_k, last_k, viol;
        logic prev_we;
        logic [W-1:0] got[$];
        rst = 1'b1; clear = 1'b0; in_vld = 1'b0; out_rdy = 1'b0; in_data = '0;
        tick();
        started = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_vld", out_vld, 0);
        chk("rst_fill", fill_cnt, 0);
        chk("rst_in_rdy", in_rdy, 1);
        chk("rst_en", {ram_write_en, ram_read_en}, 0);
        chk("rst_addr", {ram_addr_w, ram_addr_r}, 0);
        tick();

        // Single word latency.
        in_vld = 1'b1; in_data = 28'hABCDEF1; out_rdy = 1'b1;
        @(negedge clk); chk("sw_we_c0", ram_write_en, 1);
        tick(); in_vld = 1'b0;
        @(negedge clk); chk("sw_re_c1", ram_read_en, 1); chk("sw_we_c1", ram_write_en, 0);
        tick();
        @(negedge clk); chk("sw_vld_c2", out_vld, 0);
        tick();
        @(negedge clk); chk("sw_vld_c3", out_vld, 1); chk("sw_data_c3", out_data, 28'hABCDEF1);
        tick();
        @(negedge clk); chk("sw_vld_c4", out_vld, 0); chk("sw_fill_c4", fill_cnt, 0);
        tick();

        // Fill with the output stalled.
        out_rdy = 1'b0; in_vld = 1'b1; in_data = 28'h1; acc = 0; overlap = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (ram_write_en && ram_read_en) overlap++;
            if (in_vld && in_rdy) acc++;
            tick();
            in_data = W'(acc + 1);
            if (acc >= 9) in_vld = 1'b0;
        end
        in_vld = 1'b0;
        @(negedge clk);
        chk("fill_accepted", acc, 7);
        chk("fill_cnt", fill_cnt, 7);
        chk("fill_in_rdy", in_rdy, 0);
        chk("fill_overlap", overlap, 0);
        tick();

        // Drain.
        out_rdy = 1'b1; first_k = -1; last_k = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (out_vld) begin
                got.push_back(out_data);
                if (first_k < 0) first_k = k;
                last_k = k;
            end
            tick();
        end
        chk("drain_count", got.size(), 7);
        for (int i = 0; i < got.size() && i < 7; i++) chk("drain_word", got[i], i + 1);
        chk("drain_span", last_k - first_k, 6);
        @(negedge clk); chk("drain_vld_end", out_vld, 0); chk("drain_fill_end", fill_cnt, 0);
        tick();

        // Contention with RAM pre-filled.
        out_rdy = 1'b0;
        push_n(5, 28'h100);
        out_rdy = 1'b1; in_vld = 1'b1; acc = 5; in_data = 28'h105;
        got.delete(); viol = 0; prev_we = 1'b0;
        for (int k = 0; k < 200 && got.size() < 20; k++) begin
            @(negedge clk);
            if (out_vld) got.push_back(out_data);
            if (k >= 1 && (ram_write_en == ram_read_en || ram_write_en == prev_we)) viol++;
            prev_we = ram_write_en;
            if (in_rdy) acc++;
            tick();
            in_data = 28'h100 + W'(acc);
        end
        in_vld = 1'b0;
        chk("cont_pops", got.size(), 20);
        chk("cont_alternate_viol", viol, 0);
        for (int i = 0; i < got.size(); i++) chk("cont_order", got[i], 28'h100 + i);
        repeat (12) tick();
        rst = 1'b1; tick(); rst = 1'b0;

        // Reset with a read in flight and 5 words held.
        out_rdy = 1'b0;
        push_n(5, 28'h200);
        @(negedge clk); chk("mr_fill5", fill_cnt, 5);
        tick();
        out_rdy = 1'b1; in_vld = 1'b1; in_data = 28'h205;
        @(negedge clk); chk("mr_we", ram_write_en, 1);
        tick(); out_rdy = 1'b0; in_vld = 1'b0;
        @(negedge clk); chk("mr_re", ram_read_en, 1); chk("mr_fill_at_re", fill_cnt, 5);
        tick(); rst = 1'b1;
        @(negedge clk); chk("mr_en_in_rst", {ram_write_en, ram_read_en}, 0);
        tick(); rst = 1'b0; in_vld = 1'b1; in_data = 28'h55;
        @(negedge clk);
        chk("mr_vld", out_vld, 0);
        chk("mr_fill", fill_cnt, 0);
        chk("mr_in_rdy", in_rdy, 1);
        chk("mr_ptrs", {ram_addr_w, ram_addr_r}, 0);
        chk("mr_push_we", ram_write_en, 1);
        tick(); in_vld = 1'b0;
        tick();
        tick();
        @(negedge clk); chk("mr_55_vld", out_vld, 1); chk("mr_55_data", out_data, 28'h55);
        tick(); out_rdy = 1'b1;
        tick();

        // Clear with a concurrent push.
        out_rdy = 1'b0;
        push_n(2, 28'h300);
        clear = 1'b1; in_vld = 1'b1; in_data = 28'h3FF;
        @(negedge clk); chk("clr_we", ram_write_en, 0); chk("clr_re", ram_read_en, 0);
        tick(); clear = 1'b0; in_vld = 1'b0;
        @(negedge clk);
        chk("clr_fill", fill_cnt, 0);
        chk("clr_vld", out_vld, 0);
        chk("clr_in_rdy", in_rdy, 1);
        repeat (4) tick();
        @(negedge clk); chk("clr_vld_later", out_vld, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
